// File: rtl/alarm_notify_scheduler.sv
// Alarm notification sequencer: SMS first, then a voice call,
// with per-step retries, a cool-down between rounds and a sticky fault.
module alarm_notify_scheduler #(
    parameter int unsigned CLK_FREQ     = 40_000_000,
    parameter int unsigned RESP_TIMEOUT = CLK_FREQ*10-1,
    parameter int unsigned COOLDOWN     = CLK_FREQ*60-1,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       alarm_in,
    input  logic       resp_ok,
    input  logic       resp_err,
    output logic       sms_req,
    output logic       call_req,
    output logic       busy,
    output logic       fault,
    output logic [1:0] attempt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SMS,
        S_CALL,
        S_COOL,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic        gap_q, gap_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  attempt_q, attempt_d;
    logic        sms_q, sms_d;
    logic        call_q, call_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic        alarm_prev_q, alarm_prev_d;
    logic        seen_low_q, seen_low_d;

    logic        rise;
    logic        timeout;
    logic        retry_ok;
    logic [31:0] cnt_inc;

    // Edge qualifier, saturating increment and retry budget
    always_comb begin
        rise     = alarm_in & ~alarm_prev_q & seen_low_q;
        timeout  = (cnt_q == RESP_TIMEOUT);
        retry_ok = (({30'd0, attempt_q} + 32'd1) < MAX_RETRY);
        cnt_inc  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        gap_d        = 1'b0;
        cnt_d        = cnt_q;
        attempt_d    = attempt_q;
        fault_d      = fault_q;
        sms_d        = 1'b0;
        call_d       = 1'b0;
        alarm_prev_d = alarm_in;
        seen_low_d   = seen_low_q | ~alarm_in;

        if ((state_q != S_IDLE) && !enable) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            attempt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (enable && rise) begin
                        state_d   = S_SMS;
                        attempt_d = '0;
                        fault_d   = 1'b0;
                        sms_d     = 1'b1;
                    end
                end
                S_SMS, S_CALL: begin
                    if (gap_q) begin
                        // Retry gap: responses are ignored here
                        cnt_d  = '0;
                        sms_d  = (state_q == S_SMS);
                        call_d = (state_q == S_CALL);
                    end else if (resp_ok) begin
                        attempt_d = '0;
                        cnt_d     = '0;
                        if (state_q == S_SMS) begin
                            state_d = S_CALL;
                            call_d  = 1'b1;
                        end else begin
                            state_d = S_COOL;
                        end
                    end else if (resp_err || timeout) begin
                        cnt_d = '0;
                        if (retry_ok) begin
                            gap_d     = 1'b1;
                            attempt_d = attempt_q + 2'd1;
                        end else begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end
                    end else begin
                        cnt_d  = cnt_inc;
                        sms_d  = (state_q == S_SMS);
                        call_d = (state_q == S_CALL);
                    end
                end
                S_COOL: begin
                    if (cnt_q == COOLDOWN) begin
                        cnt_d = '0;
                        if (alarm_in && enable) begin
                            state_d   = S_SMS;
                            attempt_d = '0;
                            sms_d     = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_FAULT: begin
                    fault_d = 1'b1;
                    cnt_d   = '0;
                    if (!alarm_in) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    attempt_d = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gap_q        <= 1'b0;
            cnt_q        <= '0;
            attempt_q    <= '0;
            sms_q        <= 1'b0;
            call_q       <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            alarm_prev_q <= 1'b0;
            seen_low_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            cnt_q        <= cnt_d;
            attempt_q    <= attempt_d;
            sms_q        <= sms_d;
            call_q       <= call_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            alarm_prev_q <= alarm_prev_d;
            seen_low_q   <= seen_low_d;
        end
    end

    assign sms_req  = sms_q;
    assign call_req = call_q;
    assign busy     = busy_q;
    assign fault    = fault_q;
    assign attempt  = attempt_q;

endmodule

// File: tb/tb_alarm_notify_scheduler.sv
// Directed bench for alarm_notify_scheduler with short timing parameters.
module tb_alarm_notify_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       alarm_in;
    logic       resp_ok;
    logic       resp_err;
    logic       sms_req;
    logic       call_req;
    logic       busy;
    logic       fault;
    logic [1:0] attempt;

    int vectors = 0;
    int errs    = 0;

    alarm_notify_scheduler #(
        .CLK_FREQ    (1000),
        .RESP_TIMEOUT(20),
        .COOLDOWN    (50),
        .MAX_RETRY   (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .alarm_in(alarm_in),
        .resp_ok (resp_ok),
        .resp_err(resp_err),
        .sms_req (sms_req),
        .call_req(call_req),
        .busy    (busy),
        .fault   (fault),
        .attempt (attempt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic s, input logic c,
                           input logic b, input logic f,
                           input logic [1:0] a);
        chk({tag, ".sms"}, 32'(sms_req), 32'(s));
        chk({tag, ".call"}, 32'(call_req), 32'(c));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".fault"}, 32'(fault), 32'(f));
        chk({tag, ".attempt"}, 32'(attempt), 32'(a));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; alarm_in = 1'b0;
        resp_ok = 1'b0; resp_err = 1'b0;
        step(); step();
        chk_out("reset", 0, 0, 0, 0, 2'd0);
        rst = 1'b0;
        enable = 1'b1;
        step();

        // Stray responses in IDLE are ignored
        resp_ok = 1'b1; resp_err = 1'b1;
        step();
        resp_ok = 1'b0; resp_err = 1'b0;
        chk_out("idle_resp", 0, 0, 0, 0, 2'd0);

        // Happy path
        alarm_in = 1'b1;
        step();
        chk_out("hp_enter", 1, 0, 1, 0, 2'd0);
        for (int c = 1; c <= 5; c++) begin
            chk("hp_sms_hi", 32'(sms_req), 32'd1);
            if (c == 5) resp_ok = 1'b1;
            step();
            resp_ok = 1'b0;
        end
        chk_out("hp_call", 0, 1, 1, 0, 2'd0);
        for (int c = 1; c <= 3; c++) begin
            chk("hp_call_hi", 32'(call_req), 32'd1);
            if (c == 3) resp_ok = 1'b1;
            step();
            resp_ok = 1'b0;
        end
        alarm_in = 1'b0;
        chk_out("hp_cool", 0, 0, 1, 0, 2'd0);
        for (int c = 1; c <= 51; c++) begin
            chk("hp_cool_busy", 32'(busy), 32'd1);
            step();
        end
        chk_out("hp_idle", 0, 0, 0, 0, 2'd0);

        // Retry with two errors, then success
        alarm_in = 1'b1;
        step();
        chk_out("rt_a0", 1, 0, 1, 0, 2'd0);
        step();
        resp_err = 1'b1;
        step();
        resp_err = 1'b0;
        chk_out("rt_gap1", 0, 0, 1, 0, 2'd1);
        resp_ok = 1'b1;
        step();
        resp_ok = 1'b0;
        chk_out("rt_a1", 1, 0, 1, 0, 2'd1);
        resp_err = 1'b1;
        step();
        resp_err = 1'b0;
        chk_out("rt_gap2", 0, 0, 1, 0, 2'd2);
        step();
        chk_out("rt_a2", 1, 0, 1, 0, 2'd2);
        resp_ok = 1'b1;
        step();
        resp_ok = 1'b0;
        chk_out("rt_call", 0, 1, 1, 0, 2'd0);

        // Abort during CALL
        enable = 1'b0;
        step();
        chk_out("abort", 0, 0, 0, 0, 2'd0);
        enable = 1'b1;

        // Timeout exhaustion
        alarm_in = 1'b0;
        step();
        alarm_in = 1'b1;
        step();
        for (int a = 0; a < 3; a++) begin
            for (int c = 1; c <= 21; c++) begin
                chk("to_sms_hi", 32'(sms_req), 32'd1);
                chk("to_attempt", 32'(attempt), 32'(a));
                step();
            end
            if (a < 2) begin
                chk_out("to_gap", 0, 0, 1, 0, 2'(a + 1));
                step();
            end
        end
        chk_out("to_fault", 0, 0, 1, 1, 2'd2);
        step();
        chk("to_fault_hold", 32'(busy), 32'd1);
        alarm_in = 1'b0;
        step();
        chk("to_idle_busy", 32'(busy), 32'd0);
        chk("to_idle_fault", 32'(fault), 32'd1);
        alarm_in = 1'b1;
        step();
        chk_out("to_rearm", 1, 0, 1, 0, 2'd0);

        // Same-cycle ok/err counts as success
        resp_ok = 1'b1; resp_err = 1'b1;
        step();
        resp_ok = 1'b0; resp_err = 1'b0;
        chk_out("coll", 0, 1, 1, 0, 2'd0);

        // Re-notify with alarm held through COOL
        resp_ok = 1'b1;
        step();
        resp_ok = 1'b0;
        for (int c = 1; c <= 51; c++) begin
            chk("rn_cool_busy", 32'(busy), 32'd1);
            chk("rn_cool_sms", 32'(sms_req), 32'd0);
            step();
        end
        chk_out("rn_sms", 1, 0, 1, 0, 2'd0);

        // Reset mid-SMS, no restart while alarm held high
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("rst_mid", 0, 0, 0, 0, 2'd0);
        for (int c = 0; c < 5; c++) step();
        chk_out("rst_noretrig", 0, 0, 0, 0, 2'd0);
        alarm_in = 1'b0;
        step();
        alarm_in = 1'b1;
        step();
        chk_out("rst_fresh", 1, 0, 1, 0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/alarm_notify_scheduler.md
ALARM_NOTIFY_SCHEDULER -- requirements
Module: alarm_notify_scheduler

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 40_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter RESP_TIMEOUT, default CLK_FREQ*10-1, the maximum wait in cycles for a SIM response per attempt.
REQ-003 SHALL have parameter COOLDOWN, default CLK_FREQ*60-1, the hold-off in cycles between notification rounds.
REQ-004 SHALL have parameter MAX_RETRY, default 3, the number of attempts per step including the first.
REQ-005 SHALL have ports `clk` (input, 1 bit; the single clock; all logic on its rising edge) and `rst` (input, 1 bit; reset, synchronous, active-high).
REQ-006 SHALL have port `enable` (input, 1 bit): warning mode; low aborts and blocks notification.
REQ-007 SHALL have port `alarm_in` (input, 1 bit): level alarm condition, already synchronous to `clk`.
REQ-008 SHALL have port `resp_ok` (input, 1 bit): one-cycle pulse from the SIM driver when the current request succeeded.
REQ-009 SHALL have port `resp_err` (input, 1 bit): one-cycle pulse from the SIM driver when the current request failed.
REQ-010 SHALL have port `sms_req` (output, 1 bit): level SMS request to the SIM driver.
REQ-011 SHALL have port `call_req` (output, 1 bit): level voice-call request to the SIM driver.
REQ-012 SHALL have port `busy` (output, 1 bit): high in every state except IDLE.
REQ-013 SHALL have port `fault` (output, 1 bit): sticky flag, high when retries are exhausted.
REQ-014 SHALL have port `attempt` (output, 2 bits): index of the current attempt, starting at 0.

Function
REQ-015 SHALL use a state machine with states IDLE, SMS, CALL, COOL and FAULT, all outputs registered.
REQ-016 IDLE SHALL move to SMS on the first cycle where `enable` is high and `alarm_in` shows a rising edge (registered previous value 0, current value 1).
REQ-017 SMS SHALL hold `sms_req` high, `call_req` low, and run the timeout counter from 0.
REQ-018 On `resp_ok`, SMS SHALL go to CALL with `attempt` set to 0 and the counter cleared.
REQ-019 On `resp_err` or counter equal to RESP_TIMEOUT, SMS SHALL:
- deassert `sms_req` for exactly one cycle, increment `attempt`, and retry if `attempt` + 1 < MAX_RETRY;
- otherwise go to FAULT.
REQ-020 CALL SHALL behave like SMS but drive `call_req`; on `resp_ok` it SHALL go to COOL.
REQ-021 COOL SHALL count to COOLDOWN, then go to SMS if `alarm_in` and `enable` are both high, else to IDLE.
REQ-022 FAULT SHALL:
- set `fault`=1 and deassert both requests;
- return to IDLE once `alarm_in` is low;
- leave `fault` cleared only by reset or by the next IDLE->SMS transition.
REQ-023 Same-cycle `resp_ok` with `resp_err`, or with the timeout, SHALL treat the attempt as a success.
REQ-024 `resp_ok`/`resp_err` received outside SMS or CALL, or during the one-cycle retry gap, SHALL be ignored.
REQ-025 `enable` low in any state other than IDLE SHALL, on the next edge:
- go to IDLE and drop both requests;
- clear the counter and `attempt`;
- keep `fault` unchanged.
REQ-026 `sms_req` and `call_req` SHALL never be high in the same cycle.
REQ-027 The counter SHALL be 32 bits and SHALL saturate, never wrap.

Reset
REQ-028 With `rst` high at a clock edge, the block SHALL go to IDLE with `sms_req`=0, `call_req`=0, `busy`=0, `fault`=0, `attempt`=0, counter=0 and the alarm edge register=0.
REQ-029 Reset asserted mid-request SHALL drop the request on the next edge.
REQ-030 After reset, an `alarm_in` already high SHALL NOT trigger without a fresh rising edge.

Verification
All scenarios use RESP_TIMEOUT=20, COOLDOWN=50, MAX_RETRY=3.
REQ-031 Happy path: `alarm_in` rises, `resp_ok` at cycle 5 of SMS, `resp_ok` at cycle 3 of CALL -> `sms_req` high 5 cycles, then `call_req` high 3 cycles, then `busy` high 51 cycles in COOL, then IDLE.
REQ-032 Retry: `resp_err` twice during SMS, then `resp_ok` -> `attempt` reads 0, 1, 2; one-cycle gap in `sms_req` before each retry; then CALL with `attempt`=0.
REQ-033 Timeout exhaustion: no response at all -> three 21-cycle SMS attempts, then FAULT with `fault`=1; drop `alarm_in` -> IDLE with `fault` still 1; a new rising edge -> `fault` cleared and SMS entered.
REQ-034 Abort: `enable` driven low during CALL -> `call_req`=0 and `busy`=0 on the next edge; `fault` unchanged.
REQ-035 Re-notify: `alarm_in` held high through COOL -> SMS re-entered on the cycle after the counter reaches 50.
REQ-036 Collision and reset: `resp_ok` and `resp_err` in the same cycle -> success; `rst` asserted mid-SMS -> all outputs 0 on the next edge, and no restart while `alarm_in` stays high.
